rfphoenix_insn_dispatch: RTL

- Read-side consumer of the decoded-instruction FIFO.
- Pops DecodeBus/InstructionFetchbuf pairs from the FIFO head and holds them in a two-entry skid buffer.
- Presents them in order to the issue stage over a valid/ready handshake.
- Isolates the FIFO read strobe from issue-stage backpressure (no combinational ready-to-rd path), supports pipeline flush, and counts issued instructions.

---
 rtl/rfPhoenixPkg.sv | 31 +++
 rtl/rfphoenix_skid_reg2.sv | 81 ++++++++
 rtl/rfphoenix_insn_dispatch.sv | 66 ++++++
 3 files changed

// File: rtl/rfPhoenixPkg.sv
// rfPhoenix shared types: decode/fetch bundles and dispatch state.
// Imported by the dispatch skid buffer and its wrapper.
package rfPhoenixPkg;

    typedef struct packed {
        logic [15:0] tag;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } DecodeBus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        pred_taken;
    } InstructionFetchbuf;

    typedef enum logic [1:0] {
        DSP_EMPTY = 2'd0,
        DSP_ONE   = 2'd1,
        DSP_TWO   = 2'd2
    } dsp_state_e;

    typedef struct packed {
        DecodeBus           dec;
        InstructionFetchbuf ifb;
    } dsp_entry_t;

endpackage

// File: rtl/rfphoenix_skid_reg2.sv
// Generic two-entry valid/ready skid register with flush.
// Output side is driven straight from the head register.
module rfphoenix_skid_reg2
    import rfPhoenixPkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       load_i,
    input  T           data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output T           data_o,
    output logic       full_o,
    output logic [1:0] occ_o
);

    dsp_state_e state_q, state_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       fire;

    assign valid_o = (state_q != DSP_EMPTY);
    assign full_o  = (state_q == DSP_TWO);
    assign data_o  = head_q;
    assign fire    = valid_o & ready_i;
    assign occ_o   = (state_q == DSP_TWO) ? 2'd2 :
                     (state_q == DSP_ONE) ? 2'd1 : 2'd0;

    // Next-state and data steering; flush overrides everything.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            DSP_EMPTY: begin
                if (load_i) begin
                    state_d = DSP_ONE;
                    head_d  = data_i;
                end
            end
            DSP_ONE: begin
                unique case ({fire, load_i})
                    2'b11: head_d = data_i;
                    2'b10: state_d = DSP_EMPTY;
                    2'b01: begin
                        state_d = DSP_TWO;
                        tail_d  = data_i;
                    end
                    default: state_d = DSP_ONE;
                endcase
            end
            DSP_TWO: begin
                if (fire) begin
                    state_d = DSP_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = DSP_EMPTY;
        endcase
        if (flush_i) begin
            state_d = DSP_EMPTY;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DSP_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/rfphoenix_insn_dispatch.sv
// Decoded-instruction FIFO reader feeding the issue stage.
// FIFO pop depends only on registered fullness, never on iss_ready.
module rfphoenix_insn_dispatch
    import rfPhoenixPkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               fifo_v,
    input  DecodeBus           fifo_dec,
    input  InstructionFetchbuf fifo_ifb,
    output logic               fifo_rd,
    output logic               iss_valid,
    input  logic               iss_ready,
    output DecodeBus           iss_dec,
    output InstructionFetchbuf iss_ifb,
    output logic [1:0]         occ,
    output logic [CNTW-1:0]    issued_cnt
);

    dsp_entry_t      in_ent;
    dsp_entry_t      out_ent;
    logic            full;
    logic            fire;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign in_ent.dec = fifo_dec;
    assign in_ent.ifb = fifo_ifb;
    assign fifo_rd    = rst_n & fifo_v & ~flush & ~full;
    assign iss_dec    = out_ent.dec;
    assign iss_ifb    = out_ent.ifb;
    assign fire       = iss_valid & iss_ready;
    assign issued_cnt = cnt_q;

    rfphoenix_skid_reg2 #(
        .T(dsp_entry_t)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (fifo_rd),
        .data_i  (in_ent),
        .ready_i (iss_ready),
        .valid_o (iss_valid),
        .data_o  (out_ent),
        .full_o  (full),
        .occ_o   (occ)
    );

    // Handshake counter; a fire in a flush cycle still counts.
    always_comb begin
        cnt_d = cnt_q + CNTW'(fire);
    end

    // Counter register, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
